id_ex_stage: RTL

- ID/EX pipeline register plus the EX-stage operand network of the five-stage MIPS pipeline.
- Latches decoded operands and control from ID, resolves data hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's ALUCtl, A and B directly.
- Also produces the store-data/destination fields consumed by EX/MEM, and a load-use stall request for the hazard/IF-ID logic.

---
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bus: ID operands, forward sources, EX-side outputs
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          hold;
    logic          flush;
    logic          id_valid;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [3:0]    id_alu_ctl;
    logic          id_alu_src;
    logic          id_reg_dst;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_mem_to_reg;
    logic          exmem_reg_write;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_alu_out;
    logic          memwb_reg_write;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_wdata;
    logic          ex_valid;
    logic [3:0]    ALUCtl;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_dest;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic          load_use_stall;

    modport slave (
        input  hold, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_alu_ctl, id_alu_src, id_reg_dst,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               exmem_reg_write, exmem_rd, exmem_alu_out,
               memwb_reg_write, memwb_rd, memwb_wdata,
        output ex_valid, ALUCtl, A, B, ex_store_data, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               load_use_stall
    );

    modport master (
        output hold, flush, id_valid, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd, id_alu_ctl, id_alu_src, id_reg_dst,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               exmem_reg_write, exmem_rd, exmem_alu_out,
               memwb_reg_write, memwb_rd, memwb_wdata,
        input  ex_valid, ALUCtl, A, B, ex_store_data, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register with EX operand forwarding and load-use detect
// Optional macro FORWARDING_EN: EX/MEM + MEM/WB forwarding and hold-time operand refresh.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic           clk,
    input  logic           reset,
    id_ex_stage_if.slave   bus
);
    logic          valid_q, valid_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [RW-1:0] rs_q, rs_d;
    logic [RW-1:0] rt_q, rt_d;
    logic [RW-1:0] dest_q, dest_d;
    logic [3:0]    alu_ctl_q, alu_ctl_d;
    logic          alu_src_q, alu_src_d;
    logic          reg_write_q, reg_write_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          mem_to_reg_q, mem_to_reg_d;

    logic [DW-1:0] fwd_rs, fwd_rt;

`ifdef FORWARDING_EN
    // EX/MEM is checked first so the youngest producer wins; r0 is hard-wired zero.
    always_comb begin
        fwd_rs = rs_data_q;
        if (bus.exmem_reg_write && bus.exmem_rd == rs_q && rs_q != '0)
            fwd_rs = bus.exmem_alu_out;
        else if (bus.memwb_reg_write && bus.memwb_rd == rs_q && rs_q != '0)
            fwd_rs = bus.memwb_wdata;
        fwd_rt = rt_data_q;
        if (bus.exmem_reg_write && bus.exmem_rd == rt_q && rt_q != '0)
            fwd_rt = bus.exmem_alu_out;
        else if (bus.memwb_reg_write && bus.memwb_rd == rt_q && rt_q != '0)
            fwd_rt = bus.memwb_wdata;
    end

    assign bus.load_use_stall = valid_q && mem_read_q && dest_q != '0 && bus.id_valid &&
                                (dest_q == bus.id_rs || dest_q == bus.id_rt);
`else
    logic ex_hit, exmem_hit;
    logic unused_fwd;

    assign fwd_rs = rs_data_q;
    assign fwd_rt = rt_data_q;

    // Without forwarding any in-flight producer ahead of MEM/WB must stall the consumer.
    assign ex_hit    = valid_q && reg_write_q && dest_q != '0 &&
                       (dest_q == bus.id_rs || dest_q == bus.id_rt);
    assign exmem_hit = bus.exmem_reg_write && bus.exmem_rd != '0 &&
                       (bus.exmem_rd == bus.id_rs || bus.exmem_rd == bus.id_rt);
    assign bus.load_use_stall = bus.id_valid && (ex_hit || exmem_hit);

    assign unused_fwd = ^{bus.exmem_alu_out, bus.memwb_reg_write, bus.memwb_rd,
                          bus.memwb_wdata, rs_q, rt_q};
`endif

    always_comb begin
        valid_d      = valid_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        dest_d       = dest_q;
        alu_ctl_d    = alu_ctl_q;
        alu_src_d    = alu_src_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (bus.flush) begin
            valid_d      = 1'b0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_d        = '0;
            rs_d         = '0;
            rt_d         = '0;
            dest_d       = '0;
            alu_ctl_d    = '0;
            alu_src_d    = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else if (bus.hold) begin
            // Capture forwarded values so a producer retiring during the hold is not lost.
            rs_data_d = fwd_rs;
            rt_data_d = fwd_rt;
        end else begin
            valid_d      = bus.id_valid;
            rs_data_d    = bus.id_rs_data;
            rt_data_d    = bus.id_rt_data;
            imm_d        = bus.id_imm;
            rs_d         = bus.id_rs;
            rt_d         = bus.id_rt;
            dest_d       = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            alu_ctl_d    = bus.id_alu_ctl;
            alu_src_d    = bus.id_alu_src;
            reg_write_d  = bus.id_valid & bus.id_reg_write;
            mem_read_d   = bus.id_valid & bus.id_mem_read;
            mem_write_d  = bus.id_valid & bus.id_mem_write;
            mem_to_reg_d = bus.id_valid & bus.id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            dest_q       <= '0;
            alu_ctl_q    <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            dest_q       <= dest_d;
            alu_ctl_q    <= alu_ctl_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign bus.ex_valid      = valid_q;
    assign bus.ALUCtl        = alu_ctl_q;
    assign bus.A             = fwd_rs;
    assign bus.B             = alu_src_q ? imm_q : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_dest       = dest_q;
    assign bus.ex_reg_write  = reg_write_q;
    assign bus.ex_mem_read   = mem_read_q;
    assign bus.ex_mem_write  = mem_write_q;
    assign bus.ex_mem_to_reg = mem_to_reg_q;
endmodule
